// File: rtl/control_seq_pkg.sv
// rtl/control_seq_pkg.sv - shared widths, state encoding and field offsets for control_seq
//
// Purpose: default parameter values, FSM state encoding and instruction
// field-offset helpers shared by control_seq and its instruction queue.
// Ports: none (package).
package control_seq_pkg;

  localparam int              DEF_INSTR_W  = 32;
  localparam int              DEF_OPC_W    = 4;
  localparam int              DEF_ADDR_W   = 5;
  localparam int              DEF_IMM_W    = 8;
  localparam int              DEF_DEPTH    = 4;
  localparam logic [3:0]      DEF_HALT_OPC = 4'hF;

  // Field offsets for the default widths: addr1 at 0, addr2 at 5, addr3 at 10, number at 15.
  localparam int              DEF_ADDR2_LSB = DEF_ADDR_W;
  localparam int              DEF_ADDR3_LSB = 2 * DEF_ADDR_W;
  localparam int              DEF_NUM_LSB   = 3 * DEF_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // LSB of the idx-th packed field when fields are addr_w bits each, starting at bit 0.
  function automatic int field_lsb(input int addr_w, input int idx);
    return addr_w * idx;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - instruction queue for control_seq
//
// Purpose: DEPTH-entry FIFO of instruction words. Push ready is derived from
// occupancy before any same-cycle pop, so a full queue refuses a push even
// while it is being popped.
// Ports:
//   clk, reset      clock, synchronous active-high reset (flushes queue)
//   i_push_valid    push request
//   o_push_ready    queue not full
//   i_push_data     word to push
//   i_pop           pop request (ignored when empty)
//   o_pop_data      word at the head of the queue
//   o_empty         queue empty
module instr_fifo
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push_valid,
  output logic               o_push_ready,
  input  logic [INSTR_W-1:0] i_push_data,
  input  logic               i_pop,
  output logic [INSTR_W-1:0] o_pop_data,
  output logic               o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_push_ready = (r_count != CNT_W'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = i_pop && !o_empty;
  assign o_pop_data   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/control_seq.sv
// rtl/control_seq.sv - instruction queue plus issue/wait sequencer for an execution unit
//
// Purpose: queues instruction words, decodes them one at a time, issues the
// decoded fields to an execution unit, waits for completion and records the
// retired flags/result. A HALT_OPC instruction stops the sequencer until reset.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   instr_valid/instr_ready/instr_in instruction push handshake and word
//   eu_valid/eu_ready                issue handshake to the execution unit
//   eu_opcode/eu_number/eu_addr1..3  registered decoded fields
//   eu_done/eu_flag/eu_result        completion pulse with its flags/result
//   flag_cu/output_cu                last retired flags/result
//   busy/halted/retired              status and retired-instruction count
module control_seq
  import control_seq_pkg::*;
#(
  parameter int               INSTR_W  = DEF_INSTR_W,
  parameter int               OPC_W    = DEF_OPC_W,
  parameter int               ADDR_W   = DEF_ADDR_W,
  parameter int               IMM_W    = DEF_IMM_W,
  parameter int               DEPTH    = DEF_DEPTH,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'(DEF_HALT_OPC)
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               eu_valid,
  input  logic               eu_ready,
  output logic [OPC_W-1:0]   eu_opcode,
  output logic [IMM_W-1:0]   eu_number,
  output logic [ADDR_W-1:0]  eu_addr1,
  output logic [ADDR_W-1:0]  eu_addr2,
  output logic [ADDR_W-1:0]  eu_addr3,
  input  logic               eu_done,
  input  logic [7:0]         eu_flag,
  input  logic [7:0]         eu_result,
  output logic [7:0]         flag_cu,
  output logic [7:0]         output_cu,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        retired
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] WAIT  = ST_WAIT;
  localparam logic [1:0] HALT  = ST_HALT;

  localparam int A2_LSB  = field_lsb(ADDR_W, 1);
  localparam int A3_LSB  = field_lsb(ADDR_W, 2);
  localparam int NUM_LSB = field_lsb(ADDR_W, 3);

  logic [1:0]         r_state;
  logic               r_eu_valid;
  logic [OPC_W-1:0]   r_eu_opcode;
  logic [IMM_W-1:0]   r_eu_number;
  logic [ADDR_W-1:0]  r_eu_addr1;
  logic [ADDR_W-1:0]  r_eu_addr2;
  logic [ADDR_W-1:0]  r_eu_addr3;
  logic [7:0]         r_flag_cu;
  logic [7:0]         r_output_cu;
  logic [15:0]        r_retired;

  logic               w_pop;
  logic               w_empty;
  logic [INSTR_W-1:0] w_pop_data;
  logic [OPC_W-1:0]   w_opc;
  logic               w_unused_bits;

  instr_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_instr_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (instr_valid),
    .o_push_ready (instr_ready),
    .i_push_data  (instr_in),
    .i_pop        (w_pop),
    .o_pop_data   (w_pop_data),
    .o_empty      (w_empty)
  );

  // Only IDLE consumes from the queue; a halted sequencer leaves words in place.
  assign w_pop = (r_state == IDLE) && !w_empty;
  assign w_opc = w_pop_data[INSTR_W-1 -: OPC_W];
  // Bits between the number field and the opcode carry no meaning here.
  assign w_unused_bits = ^w_pop_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_eu_valid  <= 1'b0;
      r_eu_opcode <= '0;
      r_eu_number <= '0;
      r_eu_addr1  <= '0;
      r_eu_addr2  <= '0;
      r_eu_addr3  <= '0;
      r_flag_cu   <= '0;
      r_output_cu <= '0;
      r_retired   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_eu_opcode <= w_opc;
            r_eu_number <= w_pop_data[NUM_LSB +: IMM_W];
            r_eu_addr1  <= w_pop_data[0 +: ADDR_W];
            r_eu_addr2  <= w_pop_data[A2_LSB +: ADDR_W];
            r_eu_addr3  <= w_pop_data[A3_LSB +: ADDR_W];
            r_state     <= (w_opc == HALT_OPC) ? HALT : ISSUE;
          end
        end
        ISSUE: begin
          // eu_valid rises one cycle after the decode so fields are already stable.
          if (!r_eu_valid) begin
            r_eu_valid <= 1'b1;
          end else if (eu_ready) begin
            r_eu_valid <= 1'b0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (eu_done) begin
            r_flag_cu   <= eu_flag;
            r_output_cu <= eu_result;
            r_retired   <= r_retired + 16'd1;
            r_state     <= IDLE;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign eu_valid  = r_eu_valid;
  assign eu_opcode = r_eu_opcode;
  assign eu_number = r_eu_number;
  assign eu_addr1  = r_eu_addr1;
  assign eu_addr2  = r_eu_addr2;
  assign eu_addr3  = r_eu_addr3;
  assign flag_cu   = r_flag_cu;
  assign output_cu = r_output_cu;
  assign retired   = r_retired;
  assign busy      = (r_state == ISSUE) || (r_state == WAIT);
  assign halted    = (r_state == HALT);

endmodule

// File: tb/tb_control_seq.sv
// tb/tb_control_seq.sv - self-checking bench for control_seq
module tb_control_seq;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_in;
  logic        eu_valid;
  logic        eu_ready;
  logic [3:0]  eu_opcode;
  logic [7:0]  eu_number;
  logic [4:0]  eu_addr1;
  logic [4:0]  eu_addr2;
  logic [4:0]  eu_addr3;
  logic        eu_done;
  logic [7:0]  eu_flag;
  logic [7:0]  eu_result;
  logic [7:0]  flag_cu;
  logic [7:0]  output_cu;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model: accepted-but-not-issued words plus last retired values.
  logic [31:0] q[$];
  logic [7:0]  m_flag;
  logic [7:0]  m_out;
  logic [15:0] m_ret;
  bit          outstanding;

  control_seq dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_in    (instr_in),
    .eu_valid    (eu_valid),
    .eu_ready    (eu_ready),
    .eu_opcode   (eu_opcode),
    .eu_number   (eu_number),
    .eu_addr1    (eu_addr1),
    .eu_addr2    (eu_addr2),
    .eu_addr3    (eu_addr3),
    .eu_done     (eu_done),
    .eu_flag     (eu_flag),
    .eu_result   (eu_result),
    .flag_cu     (flag_cu),
    .output_cu   (output_cu),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  // Expected {opcode, number, addr3, addr2, addr1} from the instruction word.
  function automatic logic [26:0] decode(input logic [31:0] w);
    logic [3:0] opc;
    logic [7:0] num;
    logic [4:0] a1, a2, a3;
    opc = 4'(w >> 28);
    num = 8'((w >> 15) & 32'hFF);
    a3  = 5'((w >> 10) & 32'h1F);
    a2  = 5'((w >> 5) & 32'h1F);
    a1  = 5'(w & 32'h1F);
    return {opc, num, a3, a2, a1};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[31:28] = 4'($urandom_range(0, 14));
    return w;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_in    = '0;
    eu_ready    = 1'b0;
    eu_done     = 1'b0;
    eu_flag     = '0;
    eu_result   = '0;
    step();
    step();
    reset = 1'b0;
    q.delete();
    m_flag = '0;
    m_out = '0;
    m_ret = '0;
    outstanding = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_instr_ready: got %b expected 1", instr_ready);
    end
    n_cmp++;
    if (eu_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_eu_valid: got %b expected 0", eu_valid);
    end
    n_cmp++;
    if ({eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1} !== 27'd0) begin
      n_err++; $display("FAIL reset_fields: got %h expected 0", {eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1});
    end
    n_cmp++;
    if ({flag_cu, output_cu, retired} !== 32'd0) begin
      n_err++; $display("FAIL reset_cu: got %h expected 0", {flag_cu, output_cu, retired});
    end
    n_cmp++;
    if ({busy, halted} !== 2'b00) begin
      n_err++; $display("FAIL reset_status: got %b expected 00", {busy, halted});
    end
  endtask

  task automatic test_decode_latency();
    instr_valid = 1'b1;
    instr_in = 32'h10150C41;
    step();
    instr_valid = 1'b0;
    n_cmp++;
    if (eu_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_k: eu_valid got %b expected 0", eu_valid);
    end
    step();
    n_cmp++;
    if ({eu_valid, busy} !== 2'b01) begin
      n_err++; $display("FAIL lat_k1: {eu_valid,busy} got %b expected 01", {eu_valid, busy});
    end
    step();
    n_cmp++;
    if (eu_valid !== 1'b1) begin
      n_err++; $display("FAIL lat_k2: eu_valid got %b expected 1", eu_valid);
    end
    n_cmp++;
    if ({eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1} !== decode(32'h10150C41)) begin
      n_err++; $display("FAIL decode_fields: got %h expected %h",
                        {eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1}, decode(32'h10150C41));
    end
  endtask

  task automatic test_retire();
    eu_ready = 1'b1;
    step();
    eu_ready = 1'b0;
    n_cmp++;
    if ({eu_valid, busy} !== 2'b01) begin
      n_err++; $display("FAIL wait_state: {eu_valid,busy} got %b expected 01", {eu_valid, busy});
    end
    eu_done = 1'b1;
    eu_flag = 8'h81;
    eu_result = 8'h3C;
    step();
    eu_done = 1'b0;
    m_flag = 8'h81;
    m_out = 8'h3C;
    m_ret = m_ret + 16'd1;
    n_cmp++;
    if ({flag_cu, output_cu, retired, busy} !== {m_flag, m_out, m_ret, 1'b0}) begin
      n_err++; $display("FAIL retire: got %h expected %h", {flag_cu, output_cu, retired, busy}, {m_flag, m_out, m_ret, 1'b0});
    end
  endtask

  task automatic test_idle_done();
    eu_done = 1'b1;
    eu_flag = 8'h55;
    eu_result = 8'hAA;
    step();
    eu_done = 1'b0;
    step();
    n_cmp++;
    if ({flag_cu, output_cu, retired} !== {m_flag, m_out, m_ret}) begin
      n_err++; $display("FAIL idle_done_ignored: got %h expected %h", {flag_cu, output_cu, retired}, {m_flag, m_out, m_ret});
    end
  endtask

  task automatic test_fill_order();
    int          accepted;
    int          t;
    logic [31:0] w;
    logic [31:0] exp_w;
    logic [7:0]  f;
    logic [7:0]  r;
    accepted = 0;
    eu_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = rand_word();
      instr_valid = 1'b1;
      instr_in = w;
      if (instr_ready === 1'b1) begin
        q.push_back(w);
        accepted++;
      end
      step();
    end
    instr_valid = 1'b0;
    // One word waits in ISSUE while the queue itself fills to DEPTH.
    n_cmp++;
    if (accepted != DEPTH + 1) begin
      n_err++; $display("FAIL fill_accepted: got %0d expected %0d", accepted, DEPTH + 1);
    end
    n_cmp++;
    if (instr_ready !== 1'b0) begin
      n_err++; $display("FAIL fill_ready: got %b expected 0", instr_ready);
    end
    eu_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      t = 0;
      while (eu_valid !== 1'b1 && t < 20) begin
        step();
        t++;
      end
      n_cmp++;
      if (eu_valid !== 1'b1 || q.size() == 0) begin
        n_err++; $display("FAIL fill_issue_timeout: eu_valid %b expected 1 (entry %0d)", eu_valid, i);
      end else begin
        exp_w = q.pop_front();
        n_cmp++;
        if ({eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1} !== decode(exp_w)) begin
          n_err++; $display("FAIL fill_order: got %h expected %h",
                            {eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1}, decode(exp_w));
        end
        step();
        f = 8'($urandom);
        r = 8'($urandom);
        eu_done = 1'b1;
        eu_flag = f;
        eu_result = r;
        step();
        eu_done = 1'b0;
        m_flag = f;
        m_out = r;
        m_ret = m_ret + 16'd1;
        n_cmp++;
        if ({flag_cu, output_cu, retired} !== {m_flag, m_out, m_ret}) begin
          n_err++; $display("FAIL fill_retire: got %h expected %h", {flag_cu, output_cu, retired}, {m_flag, m_out, m_ret});
        end
        if (i == 0) begin
          // Queue is full while IDLE pops it this edge: the push must still be refused.
          instr_valid = 1'b1;
          instr_in = 32'hE0000000;
          n_cmp++;
          if (instr_ready !== 1'b0) begin
            n_err++; $display("FAIL full_pop_ready: got %b expected 0", instr_ready);
          end
          step();
          instr_valid = 1'b0;
          n_cmp++;
          if (instr_ready !== 1'b1) begin
            n_err++; $display("FAIL full_pop_refused: ready got %b expected 1", instr_ready);
          end
        end
      end
    end
    eu_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if ({eu_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL fill_drained: {eu_valid,busy} got %b expected 00", {eu_valid, busy});
    end
  endtask

  task automatic rand_cycle(input bit drain);
    bit          old_out;
    logic [31:0] exp_w;
    n_cmp++;
    if ({flag_cu, output_cu, retired} !== {m_flag, m_out, m_ret}) begin
      n_err++; $display("FAIL rand_cu: got %h expected %h", {flag_cu, output_cu, retired}, {m_flag, m_out, m_ret});
    end
    if (eu_valid === 1'b1 || outstanding) begin
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL rand_busy: got %b expected 1", busy);
      end
    end
    instr_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
    instr_in = rand_word();
    eu_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
    eu_flag = 8'($urandom);
    eu_result = 8'($urandom);
    eu_done = outstanding ? (drain ? 1'b1 : 1'($urandom_range(0, 1))) : ($urandom_range(0, 7) == 0);
    old_out = outstanding;
    if (instr_valid && instr_ready === 1'b1) q.push_back(instr_in);
    if (eu_done && old_out) begin
      m_flag = eu_flag;
      m_out = eu_result;
      m_ret = m_ret + 16'd1;
      outstanding = 1'b0;
    end
    if (eu_valid === 1'b1 && eu_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++; $display("FAIL rand_unexpected_issue: got %h expected none", {eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1});
      end else begin
        exp_w = q.pop_front();
        if ({eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1} !== decode(exp_w)) begin
          n_err++; $display("FAIL rand_issue: got %h expected %h",
                            {eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1}, decode(exp_w));
        end
      end
      outstanding = 1'b1;
    end
    step();
  endtask

  task automatic test_random();
    int t;
    for (int i = 0; i < 400; i++) rand_cycle(1'b0);
    t = 0;
    while ((q.size() != 0 || outstanding) && t < 300) begin
      rand_cycle(1'b1);
      t++;
    end
    eu_done = 1'b0;
    eu_ready = 1'b0;
    instr_valid = 1'b0;
    n_cmp++;
    if (q.size() != 0 || outstanding) begin
      n_err++; $display("FAIL rand_drain_timeout: pending %0d expected 0", q.size() + int'(outstanding));
    end
    step();
    n_cmp++;
    if ({flag_cu, output_cu, retired} !== {m_flag, m_out, m_ret}) begin
      n_err++; $display("FAIL rand_final: got %h expected %h", {flag_cu, output_cu, retired}, {m_flag, m_out, m_ret});
    end
  endtask

  task automatic test_reset_mid_wait();
    int t;
    bit saw_valid;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1;
      instr_in = rand_word();
      step();
    end
    instr_valid = 1'b0;
    t = 0;
    while (eu_valid !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    eu_ready = 1'b1;
    step();
    eu_ready = 1'b0;
    n_cmp++;
    if ({eu_valid, busy} !== 2'b01) begin
      n_err++; $display("FAIL rmw_in_wait: {eu_valid,busy} got %b expected 01", {eu_valid, busy});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    eu_done = 1'b1;
    eu_flag = 8'h77;
    eu_result = 8'h99;
    step();
    eu_done = 1'b0;
    n_cmp++;
    if ({instr_ready, eu_valid, busy, halted, flag_cu, output_cu, retired} !== {4'b1000, 32'd0}) begin
      n_err++; $display("FAIL rmw_reset_vals: got %h expected %h",
                        {instr_ready, eu_valid, busy, halted, flag_cu, output_cu, retired}, {4'b1000, 32'd0});
    end
    n_cmp++;
    if ({eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1} !== 27'd0) begin
      n_err++; $display("FAIL rmw_fields: got %h expected 0", {eu_opcode, eu_number, eu_addr3, eu_addr2, eu_addr1});
    end
    saw_valid = 1'b0;
    eu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (eu_valid === 1'b1) saw_valid = 1'b1;
      step();
    end
    eu_ready = 1'b0;
    n_cmp++;
    if (saw_valid || retired !== 16'd0) begin
      n_err++; $display("FAIL rmw_flushed: issued %b retired %h expected 0 0", saw_valid, retired);
    end
  endtask

  task automatic test_halt();
    bit saw_valid;
    do_reset();
    eu_ready = 1'b1;
    instr_valid = 1'b1;
    instr_in = 32'hF0000000;
    step();
    instr_in = 32'h10000000;
    step();
    instr_valid = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (eu_valid === 1'b1) saw_valid = 1'b1;
      eu_done = 1'($urandom_range(0, 1));
      step();
    end
    eu_done = 1'b0;
    n_cmp++;
    if ({halted, busy, saw_valid} !== 3'b100) begin
      n_err++; $display("FAIL halt_state: {halted,busy,issued} got %b expected 100", {halted, busy, saw_valid});
    end
    n_cmp++;
    if (retired !== 16'd0) begin
      n_err++; $display("FAIL halt_retired: got %h expected 0", retired);
    end
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++; $display("FAIL halt_ready: got %b expected 1", instr_ready);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      instr_valid = 1'b1;
      instr_in = rand_word();
      step();
    end
    instr_valid = 1'b0;
    n_cmp++;
    if ({instr_ready, halted} !== 2'b01) begin
      n_err++; $display("FAIL halt_full: {ready,halted} got %b expected 01", {instr_ready, halted});
    end
  endtask

  initial begin
    test_reset();
    test_decode_latency();
    test_retire();
    test_idle_done();
    test_fill_order();
    test_random();
    test_reset_mid_wait();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
